// File: rtl/ifm_pkg.sv
// Shared state encoding and width defaults for the IFM stream controller.
package ifm_pkg;

    localparam int unsigned IfmInW  = 512;
    localparam int unsigned IfmOutW = 64;
    localparam int unsigned IfmCntW = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } ifm_state_e;

    function automatic int unsigned lanes_of(input int unsigned in_w, input int unsigned out_w);
        return in_w / out_w;
    endfunction

    function automatic int unsigned idx_w_of(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/word_buf2.sv
// Two-entry word FIFO kept as head/tail registers so the head is always a direct flop output.
module word_buf2 #(
    parameter int unsigned W = 512
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   occupancy
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   occ_q, occ_d;
    logic         do_push, do_pop;

    always_comb begin
        do_push = push && ((occ_q < 2'd2) || pop);
        do_pop  = pop && (occ_q != 2'd0);
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        unique case ({do_push, do_pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = din;
                end else begin
                    tail_d = din;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the incoming word lands behind whatever remains.
                if (occ_q == 2'd1) begin
                    head_d = din;
                end else begin
                    head_d = tail_q;
                    tail_d = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head      = head_q;
    assign occupancy = occ_q;

endmodule

// File: rtl/ifm_stream_ctrl.sv
// Per-job controller: buffers stream words and walks them out lane by lane to the conv array.
module ifm_stream_ctrl
    import ifm_pkg::*;
#(
    parameter int unsigned IN_W  = IfmInW,
    parameter int unsigned OUT_W = IfmOutW,
    parameter int unsigned CNT_W = IfmCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             conv_start,
    input  logic [CNT_W-1:0] num_words,
    input  logic [IN_W-1:0]  s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [OUT_W-1:0] lane_data,
    output logic             lane_valid,
    input  logic             lane_ready,
    output logic             lane_last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned LANES = lanes_of(IN_W, OUT_W);
    localparam int unsigned IdxW  = idx_w_of(LANES);
    localparam logic [IdxW-1:0] LastLane = IdxW'(LANES - 1);

    ifm_state_e       state_q, state_d;
    logic [CNT_W-1:0] job_len_q, job_len_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;
    logic [IdxW-1:0]  lane_idx_q, lane_idx_d;

    logic [IN_W-1:0]  head;
    logic [1:0]       occ;
    logic             push, pop, lane_hs, at_last_lane, lane_phase;
    logic [OUT_W-1:0] lane_sel;

    word_buf2 #(
        .W (IN_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .din       (s_tdata),
        .head      (head),
        .occupancy (occ)
    );

    // Outputs depend only on registered state, never combinationally on lane_ready.
    always_comb begin
        lane_phase   = (state_q == StRun) || (state_q == StDrain);
        s_tready     = (state_q == StRun) && (occ < 2'd2) && (rx_cnt_q < job_len_q);
        push         = s_tvalid && s_tready;
        lane_valid   = lane_phase && (occ != 2'd0);
        at_last_lane = (lane_idx_q == LastLane);
        lane_last    = lane_valid && at_last_lane && (pop_cnt_q == job_len_q - CNT_W'(1));
        lane_hs      = lane_valid && lane_ready;
        pop          = lane_hs && at_last_lane;
        busy         = (state_q != StIdle);
        done         = (state_q == StDone);

        lane_sel = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (lane_idx_q == IdxW'(i)) begin
                lane_sel = head[i*OUT_W +: OUT_W];
            end
        end
        lane_data = lane_valid ? lane_sel : '0;
    end

    always_comb begin
        state_d    = state_q;
        job_len_d  = job_len_q;
        rx_cnt_d   = rx_cnt_q + CNT_W'(push);
        pop_cnt_d  = pop_cnt_q + CNT_W'(pop);
        lane_idx_d = lane_idx_q;
        if (lane_hs) begin
            lane_idx_d = at_last_lane ? '0 : lane_idx_q + IdxW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (conv_start) begin
                    if (num_words != '0) begin
                        job_len_d  = num_words;
                        rx_cnt_d   = '0;
                        pop_cnt_d  = '0;
                        lane_idx_d = '0;
                        state_d    = StRun;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (rx_cnt_d == job_len_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (lane_hs && lane_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            job_len_q  <= '0;
            rx_cnt_q   <= '0;
            pop_cnt_q  <= '0;
            lane_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            job_len_q  <= job_len_d;
            rx_cnt_q   <= rx_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            lane_idx_q <= lane_idx_d;
        end
    end

endmodule

// File: tb/tb_ifm_stream_ctrl.sv
// Scoreboard bench for ifm_stream_ctrl: accepted words queue their lanes, the monitor pops and compares.
module tb_ifm_stream_ctrl;

    localparam int unsigned InW   = 512;
    localparam int unsigned OutW  = 64;
    localparam int unsigned CntW  = 16;
    localparam int unsigned Lanes = InW / OutW;

    logic            clk        = 1'b0;
    logic            rst        = 1'b1;
    logic            conv_start = 1'b0;
    logic [CntW-1:0] num_words  = '0;
    logic [InW-1:0]  s_tdata    = '0;
    logic            s_tvalid   = 1'b0;
    logic            lane_ready = 1'b0;
    logic            s_tready;
    logic [OutW-1:0] lane_data;
    logic            lane_valid;
    logic            lane_last;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    ifm_stream_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .conv_start (conv_start),
        .num_words  (num_words),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .lane_data  (lane_data),
        .lane_valid (lane_valid),
        .lane_ready (lane_ready),
        .lane_last  (lane_last),
        .busy       (busy),
        .done       (done)
    );

    typedef struct packed {
        logic [OutW-1:0] data;
        logic            last;
        logic [2:0]      idx;
    } lane_t;

    lane_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lane_cnt = 0, done_cnt = 0, drop_cnt = 0, stall_cnt = 0, full_cnt = 0;
    int last_hs_cyc = 0, done_cyc = 0, occ_m = 0;
    bit mon_en = 0, abort = 0, ready_toggle = 0, ready_level = 1;
    bit stall_prev = 0, done_prev = 0, valid_prev = 0;
    logic [OutW-1:0] stall_data = '0;

    task automatic check_eq(input string tag, input logic [OutW-1:0] got,
                            input logic [OutW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        lane_ready = ready_toggle ? ~lane_ready : ready_level;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            lane_t e;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_prev) check_eq("busy_after_done", 64'(busy), 0);
            if (valid_prev && !lane_valid && busy && !done) drop_cnt++;
            if (occ_m == 2) begin
                full_cnt++;
                check_eq("s_tready_when_full", 64'(s_tready), 0);
            end
            if (stall_prev) begin
                check_eq("stall_valid_held", 64'(lane_valid), 1);
                check_eq("stall_data_held", lane_data, stall_data);
            end
            if (!lane_valid) check_eq("idle_lane_data", lane_data, 0);
            if (s_tvalid && s_tready) occ_m++;
            stall_prev = 0;
            if (lane_valid && lane_ready) begin
                check_eq("lane_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("lane_data", lane_data, e.data);
                    check_eq("lane_last", 64'(lane_last), 64'(e.last));
                    if (e.idx == 3'(Lanes - 1)) occ_m--;
                end
                lane_cnt++;
                if (lane_last) last_hs_cyc = cyc;
            end else if (lane_valid) begin
                stall_prev = 1;
                stall_data = lane_data;
                stall_cnt++;
            end
            done_prev  = done;
            valid_prev = lane_valid;
        end
    end

    task automatic drive_words(input int n, input int gap, input int job_len, input bit byte_pat);
        logic [InW-1:0] w;
        lane_t          e;
        bit             acc;
        int             t;
        for (int k = 0; k < n && !abort; k++) begin
            for (int b = 0; b < int'(InW / 32); b++) w[b*32 +: 32] = $urandom;
            if (byte_pat) for (int b = 0; b < int'(InW / 8); b++) w[b*8 +: 8] = 8'(b);
            s_tdata  = w;
            s_tvalid = 1'b1;
            acc      = 0;
            t        = 0;
            while (!acc && !abort && t < 500) begin
                @(negedge clk);
                acc = s_tready;
                @(posedge clk);
                #1;
                t++;
            end
            if (abort) break;
            check_eq("word_accepted", 64'(acc), 1);
            for (int l = 0; l < int'(Lanes); l++) begin
                e.data = w[l*OutW +: OutW];
                e.last = (k == job_len - 1) && (l == int'(Lanes) - 1);
                e.idx  = 3'(l);
                exp_q.push_back(e);
            end
            s_tvalid = 1'b0;
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic start_job(input int n);
        conv_start = 1'b1;
        num_words  = CntW'(n);
        @(posedge clk);
        #1;
        conv_start = 1'b0;
        num_words  = '0;
    endtask

    task automatic wait_done(input int base, input int limit);
        int t = 0;
        while (done_cnt == base && t < limit) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("done_seen", 64'(done_cnt - base), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_s_tready"}, 64'(s_tready), 0);
        check_eq({tag, "_lane_valid"}, 64'(lane_valid), 0);
        check_eq({tag, "_lane_last"}, 64'(lane_last), 0);
        check_eq({tag, "_busy"}, 64'(busy), 0);
        check_eq({tag, "_done"}, 64'(done), 0);
        check_eq({tag, "_lane_data"}, lane_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_l, base_d, base_x, c0, t;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1;

        // 1: three-word job, continuous stream, always ready
        base_l = lane_cnt;
        base_d = done_cnt;
        start_job(3);
        fork
            drive_words(3, 0, 3, 0);
            wait_done(base_d, 500);
        join
        repeat (3) @(posedge clk);
        #1;
        check_eq("t1_lane_count", 64'(lane_cnt - base_l), 24);
        check_eq("t1_done_count", 64'(done_cnt - base_d), 1);
        check_eq("t1_done_after_last", 64'(done_cyc - last_hs_cyc), 1);
        check_eq("t1_queue_empty", 64'(exp_q.size()), 0);

        // 2: toggling lane_ready with byte-ramp words
        ready_toggle = 1;
        base_l = lane_cnt;
        base_d = done_cnt;
        base_x = full_cnt;
        t      = stall_cnt;
        start_job(3);
        fork
            drive_words(3, 0, 3, 1);
            wait_done(base_d, 500);
        join
        ready_toggle = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t2_lane_count", 64'(lane_cnt - base_l), 24);
        check_eq("t2_stalls_seen", 64'(stall_cnt > t), 1);
        check_eq("t2_full_seen", 64'(full_cnt > base_x), 1);

        // 3: zero-length job
        base_d = done_cnt;
        c0     = cyc;
        start_job(0);
        repeat (3) begin
            @(negedge clk);
            check_eq("t3_s_tready", 64'(s_tready), 0);
            check_eq("t3_lane_valid", 64'(lane_valid), 0);
        end
        @(posedge clk);
        #1;
        check_eq("t3_done_count", 64'(done_cnt - base_d), 1);
        check_eq("t3_done_latency", 64'((done_cyc - c0) <= 2), 1);

        // 4: conv_start re-pulsed mid-job is ignored
        base_l = lane_cnt;
        base_d = done_cnt;
        start_job(2);
        fork
            drive_words(2, 0, 2, 0);
            begin
                int tw = 0;
                while (lane_cnt < base_l + 3 && tw < 200) begin
                    @(posedge clk);
                    #1;
                    tw++;
                end
                conv_start = 1'b1;
                num_words  = CntW'(9);
                @(posedge clk);
                #1;
                conv_start = 1'b0;
                num_words  = '0;
            end
            wait_done(base_d, 500);
        join
        repeat (20) @(posedge clk);
        #1;
        check_eq("t4_lane_count", 64'(lane_cnt - base_l), 16);
        check_eq("t4_done_count", 64'(done_cnt - base_d), 1);
        check_eq("t4_idle_after", 64'(busy), 0);

        // 5: reset mid-job, then a fresh one-word job
        base_l = lane_cnt;
        base_d = done_cnt;
        start_job(4);
        fork
            drive_words(4, 0, 4, 0);
            begin
                int tw = 0;
                while (lane_cnt < base_l + 5 && tw < 200) begin
                    @(posedge clk);
                    #1;
                    tw++;
                end
                rst   = 1'b1;
                abort = 1;
                @(posedge clk);
                #1;
            end
        join
        @(negedge clk);
        exp_q.delete();
        occ_m      = 0;
        stall_prev = 0;
        check_outputs_zero("t5_abort");
        @(posedge clk);
        #1;
        rst   = 1'b0;
        abort = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("t5_no_done_on_abort", 64'(done_cnt - base_d), 0);
        base_l = lane_cnt;
        base_d = done_cnt;
        start_job(1);
        fork
            drive_words(1, 0, 1, 0);
            wait_done(base_d, 500);
        join
        repeat (3) @(posedge clk);
        #1;
        check_eq("t5_fresh_lanes", 64'(lane_cnt - base_l), 8);

        // 6: sparse stream, one word every 20 cycles
        base_l = lane_cnt;
        base_d = done_cnt;
        base_x = drop_cnt;
        start_job(3);
        fork
            drive_words(3, 20, 3, 0);
            wait_done(base_d, 1000);
        join
        repeat (3) @(posedge clk);
        #1;
        check_eq("t6_lane_count", 64'(lane_cnt - base_l), 24);
        check_eq("t6_valid_drops", 64'((drop_cnt - base_x) >= 2), 1);
        check_eq("t6_queue_empty", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
